// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_LANES VLIW memory slots.
// Define DMEM_ARB_STATS_EN to add the saturating ConflictCount output.

module data_memory_arbiter_lane #(
  parameter int NUM_LANES = 2,
  parameter int LANE      = 0
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [1:0]           start,
  input  logic                 done,
  input  logic [1:0]           grant,
  output logic                 win,
  output logic                 ack
);
  int   my_d, d;
  logic blocked;

  // A lane wins when no requesting lane sits closer to the rotating start pointer.
  always_comb begin
    blocked = 1'b0;
    d       = 0;
    my_d    = (LANE + NUM_LANES - int'(start)) % NUM_LANES;
    for (int j = 0; j < NUM_LANES; j++) begin
      d = (j + NUM_LANES - int'(start)) % NUM_LANES;
      if (req[j] && (d < my_d)) blocked = 1'b1;
    end
  end

  assign win = req[LANE] & ~blocked;
  assign ack = done & (grant == 2'(LANE));
endmodule

module data_memory_arbiter #(
  parameter int NUM_LANES = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [NUM_LANES-1:0]        Req,
  input  logic [NUM_LANES-1:0]        ReqWrite,
  input  logic [NUM_LANES*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_LANES*DATA_W-1:0] ReqWData,
  output logic [NUM_LANES-1:0]        Ack,
  output logic [DATA_W-1:0]           RespData,
  output logic [1:0]                  GrantLane,
  output logic                        Busy,
  output logic [ADDR_W-1:0]           Address,
  output logic [DATA_W-1:0]           WriteData,
  output logic                        MemWriteEnable,
  input  logic [DATA_W-1:0]           ReadData
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]                 ConflictCount
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                             state, state_nxt;
  logic                               capture;
  logic [1:0]                         last_grant, start, win_idx;
  logic [NUM_LANES-1:0]               win;
  logic [NUM_LANES-1:0][ADDR_W-1:0]   req_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0]   req_wdata;
  req_t                               sel, cap;

  assign req_addr  = ReqAddr;
  assign req_wdata = ReqWData;
  assign start     = (last_grant == 2'(NUM_LANES-1)) ? 2'd0 : last_grant + 2'd1;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      data_memory_arbiter_lane #(
        .NUM_LANES(NUM_LANES),
        .LANE     (i)
      ) u_lane (
        .req  (Req),
        .start(start),
        .done (state == DONE),
        .grant(GrantLane),
        .win  (win[i]),
        .ack  (Ack[i])
      );
    end
  endgenerate

  // win is one-hot (or zero), so a priority-free OR-style mux is enough.
  always_comb begin
    win_idx = 2'd0;
    sel     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (win[i]) begin
        win_idx   = 2'(i);
        sel.wr    = ReqWrite[i];
        sel.addr  = req_addr[i];
        sel.wdata = req_wdata[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE:    if (|Req) begin
                 capture   = 1'b1;
                 state_nxt = ACCESS;
               end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 2'(NUM_LANES-1);
      GrantLane  <= 2'd0;
      cap        <= '0;
      RespData   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        GrantLane <= win_idx;
        cap       <= sel;
      end
      if (state == ACCESS) begin
        last_grant <= GrantLane;
        if (!cap.wr) RespData <= ReadData;
      end
    end
  end

  assign Busy           = (state != IDLE);
  assign Address        = (state == ACCESS) ? cap.addr  : '0;
  assign WriteData      = (state == ACCESS) ? cap.wdata : '0;
  // Gated by Reset so an abandoned access never reaches the memory.
  assign MemWriteEnable = (state == ACCESS) & cap.wr & ~Reset;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (Reset)
      ConflictCount <= '0;
    else if (capture && ($countones(Req) >= 2) && (ConflictCount != 16'hFFFF))
      ConflictCount <= ConflictCount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table of single ops plus contention, fairness, reset and idle sequences.
module tb_data_memory_arbiter;
  localparam int N = 2, AW = 8, DW = 8;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [N-1:0]    Req, ReqWrite, Ack;
  logic [N*AW-1:0] ReqAddr;
  logic [N*DW-1:0] ReqWData;
  logic [DW-1:0]   RespData, WriteData, ReadData;
  logic [1:0]      GrantLane;
  logic            Busy, MemWriteEnable;
  logic [AW-1:0]   Address;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]     ConflictCount;
`endif

  data_memory_arbiter #(.NUM_LANES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .Ack(Ack), .RespData(RespData), .GrantLane(GrantLane),
    .Busy(Busy), .Address(Address), .WriteData(WriteData),
    .MemWriteEnable(MemWriteEnable), .ReadData(ReadData)
`ifdef DMEM_ARB_STATS_EN
    , .ConflictCount(ConflictCount)
`endif
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  always @(posedge CLK) if (MemWriteEnable) mem[Address] <= WriteData;
  assign ReadData = mem[Address];

  logic       lreq [N];
  logic       lwr  [N];
  logic [7:0] laddr[N];
  logic [7:0] ldata[N];
  always_comb begin
    Req = '0; ReqWrite = '0; ReqAddr = '0; ReqWData = '0;
    for (int i = 0; i < N; i++) begin
      Req[i] = lreq[i];
      ReqWrite[i] = lwr[i];
      ReqAddr[i*AW +: AW] = laddr[i];
      ReqWData[i*DW +: DW] = ldata[i];
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic load; logic [7:0] data; } exp_t;
  exp_t       q0[$], q1[$];
  int         ack_log[$];
  logic [7:0] mdl_resp = 8'h00;

  // Scoreboard: every Ack pops the expected outcome queued when that lane was driven.
  always @(negedge CLK) begin
    exp_t e;
    int   ln;
    if (Reset) mdl_resp = 8'h00;
    if (Ack != '0) begin
      chk("ack_onehot", 32'($onehot(Ack)), 32'd1);
      ln = Ack[1] ? 1 : 0;
      ack_log.push_back(ln);
      chk("grant_lane", 32'(GrantLane), 32'(ln));
      if ((ln == 0 && q0.size() == 0) || (ln == 1 && q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_ack: lane %0d acked with nothing pending", ln);
      end else begin
        e = (ln == 0) ? q0.pop_front() : q1.pop_front();
        if (e.load) begin
          chk("resp_load", 32'(RespData), 32'(e.data));
          mdl_resp = e.data;
        end else
          chk("resp_store_hold", 32'(RespData), 32'(mdl_resp));
      end
    end
  end

  // Call #1 after a posedge; returns the negedge index of the Ack plus write-enable activity.
  task automatic run_op(input int lane, input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] ed, output int lat, output int wc, output int wk, output logic [7:0] wa);
    exp_t e;
    lreq[lane] = 1'b1; lwr[lane] = wr; laddr[lane] = addr; ldata[lane] = wdata;
    e.load = !wr; e.data = ed;
    if (lane == 0) q0.push_back(e); else q1.push_back(e);
    lat = -1; wc = 0; wk = -1; wa = 8'h00;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (MemWriteEnable) begin wc++; wk = k; wa = Address; end
      if (Ack[lane]) begin lat = k; break; end
    end
    @(posedge CLK); #1;
    lreq[lane] = 1'b0;
  endtask

  typedef struct { int lane; logic wr; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp; } vec_t;
  vec_t vt[8];

  int lat_a, wc_a, wk_a, lat_b, wc_b, wk_b, lat_c, wc_c, wk_c, lat_d, wc_d, wk_d;
  logic [7:0] wa_a, wa_b, wa_c, wa_d;

  initial begin
    vt[0] = '{0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vt[1] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vt[2] = '{1, 1'b1, 8'hFF, 8'h3C, 8'h00};
    vt[3] = '{0, 1'b0, 8'hFF, 8'h00, 8'h3C};
    vt[4] = '{0, 1'b1, 8'h00, 8'h11, 8'h00};
    vt[5] = '{1, 1'b1, 8'h7F, 8'h22, 8'h00};
    vt[6] = '{0, 1'b0, 8'h7F, 8'h00, 8'h22};
    vt[7] = '{1, 1'b0, 8'h00, 8'h00, 8'h11};

    for (int i = 0; i < N; i++) begin lreq[i] = 0; lwr[i] = 0; laddr[i] = 0; ldata[i] = 0; end
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_resp", 32'(RespData), 32'd0);
    chk("rst_grant", 32'(GrantLane), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_wen", 32'(MemWriteEnable), 32'd0);
    chk("rst_addr", 32'(Address), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_conflict", 32'(ConflictCount), 32'd0);
`endif
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].lane, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp, lat_a, wc_a, wk_a, wa_a);
      chk($sformatf("vec%0d_latency", i), 32'(lat_a), 32'd2);
      chk($sformatf("vec%0d_wen_count", i), 32'(wc_a), vt[i].wr ? 32'd1 : 32'd0);
      if (vt[i].wr) begin
        chk($sformatf("vec%0d_wen_cycle", i), 32'(wk_a), 32'd1);
        chk($sformatf("vec%0d_wen_addr", i), 32'(wa_a), 32'(vt[i].addr));
      end
    end
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_none", 32'(ConflictCount), 32'd0);
`endif

    // Contention: both lanes load in the same cycle; lane0 wins first.
    ack_log.delete();
    fork
      begin run_op(0, 1'b0, 8'h10, 8'h00, 8'hA5, lat_a, wc_a, wk_a, wa_a); end
      begin run_op(1, 1'b0, 8'hFF, 8'h00, 8'h3C, lat_b, wc_b, wk_b, wa_b); end
    join
    chk("cont_lat0", 32'(lat_a), 32'd2);
    chk("cont_lat1", 32'(lat_b), 32'd5);
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_one", 32'(ConflictCount), 32'd1);
`endif

    // Fairness: both lanes keep requesting; grants must alternate.
    ack_log.delete();
    fork
      begin
        run_op(0, 1'b0, 8'h10, 8'h00, 8'hA5, lat_a, wc_a, wk_a, wa_a);
        run_op(0, 1'b0, 8'h7F, 8'h00, 8'h22, lat_c, wc_c, wk_c, wa_c);
      end
      begin
        run_op(1, 1'b0, 8'hFF, 8'h00, 8'h3C, lat_b, wc_b, wk_b, wa_b);
        run_op(1, 1'b0, 8'h00, 8'h00, 8'h11, lat_d, wc_d, wk_d, wa_d);
      end
    join
    chk("fair_lat0a", 32'(lat_a), 32'd2);
    chk("fair_lat1a", 32'(lat_b), 32'd5);
    chk("fair_lat0b", 32'(lat_c), 32'd5);
    chk("fair_lat1b", 32'(lat_d), 32'd5);
    chk("fair_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk($sformatf("fair_order%0d", i), 32'(ack_log[i]), 32'(i % 2));
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_fair", 32'(ConflictCount), 32'd4);
`endif

    // Reset during ACCESS of a captured store: no write, no Ack.
    lreq[0] = 1'b1; lwr[0] = 1'b1; laddr[0] = 8'h10; ldata[0] = 8'h77;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(negedge CLK);
    chk("rmo_wen_in_access", 32'(MemWriteEnable), 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0; lreq[0] = 1'b0; lwr[0] = 1'b0;
    @(negedge CLK);
    chk("rmo_ack", 32'(Ack), 32'd0);
    chk("rmo_busy", 32'(Busy), 32'd0);
    chk("rmo_grant", 32'(GrantLane), 32'd0);
    chk("rmo_resp", 32'(RespData), 32'd0);
    chk("rmo_wen", 32'(MemWriteEnable), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("rmo_no_ack", 32'(Ack), 32'd0);
    end
    @(posedge CLK); #1;
    run_op(1, 1'b0, 8'h10, 8'h00, 8'hA5, lat_a, wc_a, wk_a, wa_a);
    chk("rmo_reload_lat", 32'(lat_a), 32'd2);

    // Idle: nothing requested.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("idle%0d", i), {29'd0, Busy, MemWriteEnable, |Ack}, 32'd0);
    end

    chk("sb_q0_empty", 32'(q0.size()), 32'd0);
    chk("sb_q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
